mc_sequencer: RTL and testbench

- Multi-cycle control FSM for the MIPS-subset datapath.
- Steps a shared datapath (single ALU, single memory port, IR/PC/ALUOut registers) through FETCH, DECODE, EXEC, MEM and WB.
- Arbitrates the one memory port between instruction fetch and data access, using a req/ack handshake.
- Replaces the single-cycle control decode. Decoded controls are the same: reg_dest, reg_write, mem_to_reg, mem_write, and PC select.

---
 rtl/mc_sequencer_if.sv | 53 +++++
 rtl/mc_sequencer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc_sequencer_if
//  Description : Control/handshake bundle between the multi-cycle sequencer
//                and the shared datapath / memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mc_sequencer_if;
  // Instruction fields and datapath status
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ack;

  // Memory port control
  logic       mem_req;
  logic       mem_we;
  logic       iord;

  // Datapath control
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic [2:0] alu_op;
  logic       reg_dest;
  logic       reg_write;
  logic       mem_to_reg;

  // Status
  logic       retire;
  logic       trap;
  logic [2:0] state;

  // Sequencer side
  modport slave (
    input  opcode, funct, zero, mem_ack,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, ext_zero, alu_op, reg_dest,
           reg_write, mem_to_reg, retire, trap, state
  );

  // Datapath / memory side
  modport master (
    output opcode, funct, zero, mem_ack,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, ext_zero, alu_op, reg_dest,
           reg_write, mem_to_reg, retire, trap, state
  );
endinterface
`default_nettype wire

// File: rtl/mc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mc_sequencer
//  Description : Multi-cycle control FSM for the MIPS-subset datapath. Walks
//                the shared ALU / memory port through FETCH, DECODE, EXEC,
//                MEM and WB, with a req/ack memory handshake and a wait
//                timeout that drops into a sticky TRAP state.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic           clk,
  input  logic           rst,
  mc_sequencer_if.slave  bus
);

  // State encoding is visible on the state output, so values are fixed
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ADDIU = 6'b001001;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_SLT = 3'b100;

  // The trap fires on the request cycle whose wait count equals
  // MEM_TIMEOUT-1, i.e. the MEM_TIMEOUT-th cycle without an ack.
  localparam bit               c_TIMEOUT_EN   = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX      = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;

  logic       w_req_state;
  logic       w_wait;
  logic       w_timeout;
  logic       w_is_rtype;
  logic       w_rtype_legal;
  logic       w_itype_legal;
  logic [2:0] w_rtype_alu_op;

  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_iord;
  logic       w_ir_write;
  logic       w_pc_write;
  logic [1:0] w_pc_src;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic       w_ext_zero;
  logic [2:0] w_alu_op;
  logic       w_reg_dest;
  logic       w_reg_write;
  logic       w_mem_to_reg;
  logic       w_retire;
  logic       w_trap;

  assign w_req_state = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_wait      = w_req_state && !bus.mem_ack;
  assign w_timeout   = c_TIMEOUT_EN && w_wait && (r_wait_cnt == c_TIMEOUT_LAST);
  assign w_is_rtype  = (bus.opcode == c_OP_RTYPE);

  // Instruction legality and R-type ALU function decode
  always_comb begin
    w_rtype_legal  = 1'b0;
    w_rtype_alu_op = c_ALU_ADD;
    case (bus.funct)
      6'h20, 6'h21: begin w_rtype_legal = 1'b1; w_rtype_alu_op = c_ALU_ADD; end
      6'h22, 6'h23: begin w_rtype_legal = 1'b1; w_rtype_alu_op = c_ALU_SUB; end
      6'h24:        begin w_rtype_legal = 1'b1; w_rtype_alu_op = c_ALU_AND; end
      6'h25:        begin w_rtype_legal = 1'b1; w_rtype_alu_op = c_ALU_OR;  end
      6'h2A:        begin w_rtype_legal = 1'b1; w_rtype_alu_op = c_ALU_SLT; end
      default:      begin w_rtype_legal = 1'b0; w_rtype_alu_op = c_ALU_ADD; end
    endcase
    w_itype_legal = (bus.opcode == c_OP_ADDI) || (bus.opcode == c_OP_ADDIU) ||
                    (bus.opcode == c_OP_ANDI) || (bus.opcode == c_OP_BEQ)   ||
                    (bus.opcode == c_OP_BNE)  || (bus.opcode == c_OP_LW)    ||
                    (bus.opcode == c_OP_SW)   || (bus.opcode == c_OP_J);
  end

  // State transitions and memory wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      // Any cycle that is not an unanswered request restarts the count,
      // which covers every entry into FETCH or MEM.
      if (w_wait) begin
        if (r_wait_cnt != c_CNT_MAX) begin
          r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
      end else begin
        r_wait_cnt <= '0;
      end

      case (r_state)
        S_FETCH: begin
          if (bus.mem_ack) begin
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_state <= S_TRAP;
          end
        end
        S_DECODE: begin
          if ((w_is_rtype && w_rtype_legal) || w_itype_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_state <= S_TRAP;
          end
        end
        S_EXEC: begin
          if ((bus.opcode == c_OP_LW) || (bus.opcode == c_OP_SW)) begin
            r_state <= S_MEM;
          end else if ((bus.opcode == c_OP_BEQ) || (bus.opcode == c_OP_BNE) ||
                       (bus.opcode == c_OP_J)) begin
            r_state <= S_FETCH;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            r_state <= (bus.opcode == c_OP_LW) ? S_WB : S_FETCH;
          end else if (w_timeout) begin
            r_state <= S_TRAP;
          end
        end
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_TRAP;
      endcase
    end
  end

  // Control outputs decoded from state and live inputs; all forced low in reset
  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 2'b00;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_ext_zero   = 1'b0;
    w_alu_op     = c_ALU_ADD;
    w_reg_dest   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_retire     = 1'b0;
    w_trap       = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC + 4 is computed while the instruction is read
        w_mem_req   = 1'b1;
        w_alu_src_b = 2'b01;
        if (bus.mem_ack) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut
        w_alu_src_b = 2'b11;
      end
      S_EXEC: begin
        if (w_is_rtype) begin
          w_alu_src_a = 1'b1;
          w_alu_op    = w_rtype_alu_op;
        end else begin
          case (bus.opcode)
            c_OP_ADDI, c_OP_ADDIU, c_OP_LW, c_OP_SW: begin
              w_alu_src_a = 1'b1;
              w_alu_src_b = 2'b10;
            end
            c_OP_ANDI: begin
              w_alu_src_a = 1'b1;
              w_alu_src_b = 2'b10;
              w_ext_zero  = 1'b1;
              w_alu_op    = c_ALU_AND;
            end
            c_OP_BEQ, c_OP_BNE: begin
              w_alu_src_a = 1'b1;
              w_alu_op    = c_ALU_SUB;
              w_pc_src    = 2'b01;
              w_pc_write  = (bus.opcode == c_OP_BEQ) ? bus.zero : !bus.zero;
              w_retire    = 1'b1;
            end
            c_OP_J: begin
              w_pc_write = 1'b1;
              w_pc_src   = 2'b10;
              w_retire   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        w_mem_we  = (bus.opcode == c_OP_SW);
        w_retire  = bus.mem_ack && (bus.opcode == c_OP_SW);
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_reg_dest   = w_is_rtype;
        w_mem_to_reg = (bus.opcode == c_OP_LW);
      end
      S_TRAP: begin
        w_trap = 1'b1;
      end
      default: ;
    endcase

    // A request in flight is simply dropped while reset is held
    if (rst) begin
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_iord       = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_src     = 2'b00;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = 2'b00;
      w_ext_zero   = 1'b0;
      w_alu_op     = c_ALU_ADD;
      w_reg_dest   = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_to_reg = 1'b0;
      w_retire     = 1'b0;
      w_trap       = 1'b0;
    end
  end

  assign bus.mem_req    = w_mem_req;
  assign bus.mem_we     = w_mem_we;
  assign bus.iord       = w_iord;
  assign bus.ir_write   = w_ir_write;
  assign bus.pc_write   = w_pc_write;
  assign bus.pc_src     = w_pc_src;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.ext_zero   = w_ext_zero;
  assign bus.alu_op     = w_alu_op;
  assign bus.reg_dest   = w_reg_dest;
  assign bus.reg_write  = w_reg_write;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.retire     = w_retire;
  assign bus.trap       = w_trap;
  assign bus.state      = rst ? 3'd0 : r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_sequencer
//  Description : Directed self-checking bench for mc_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mc_sequencer_if bus ();

  mc_sequencer #(
    .MEM_TIMEOUT (15),
    .CNT_W       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Packed control word:
  // req we iord irw pcw _ pcsrc _ asa asb ext _ aluop _ rd rw m2r ret trap
  localparam logic [18:0] ZERO_C   = 19'b0_0_0_0_0_00_0_00_0_000_0_0_0_0_0;
  localparam logic [18:0] F_WAIT   = 19'b1_0_0_0_0_00_0_01_0_000_0_0_0_0_0;
  localparam logic [18:0] F_ACK    = 19'b1_0_0_1_1_00_0_01_0_000_0_0_0_0_0;
  localparam logic [18:0] DEC      = 19'b0_0_0_0_0_00_0_11_0_000_0_0_0_0_0;
  localparam logic [18:0] EX_R_ADD = 19'b0_0_0_0_0_00_1_00_0_000_0_0_0_0_0;
  localparam logic [18:0] EX_R_SUB = 19'b0_0_0_0_0_00_1_00_0_001_0_0_0_0_0;
  localparam logic [18:0] EX_R_SLT = 19'b0_0_0_0_0_00_1_00_0_100_0_0_0_0_0;
  localparam logic [18:0] EX_IMM   = 19'b0_0_0_0_0_00_1_10_0_000_0_0_0_0_0;
  localparam logic [18:0] EX_ANDI  = 19'b0_0_0_0_0_00_1_10_1_010_0_0_0_0_0;
  localparam logic [18:0] EX_BR_T  = 19'b0_0_0_0_1_01_1_00_0_001_0_0_0_1_0;
  localparam logic [18:0] EX_BR_N  = 19'b0_0_0_0_0_01_1_00_0_001_0_0_0_1_0;
  localparam logic [18:0] EX_J     = 19'b0_0_0_0_1_10_0_00_0_000_0_0_0_1_0;
  localparam logic [18:0] MEM_LW   = 19'b1_0_1_0_0_00_0_00_0_000_0_0_0_0_0;
  localparam logic [18:0] MEM_SW   = 19'b1_1_1_0_0_00_0_00_0_000_0_0_0_0_0;
  localparam logic [18:0] MEM_SWA  = 19'b1_1_1_0_0_00_0_00_0_000_0_0_0_1_0;
  localparam logic [18:0] WB_R     = 19'b0_0_0_0_0_00_0_00_0_000_1_1_0_1_0;
  localparam logic [18:0] WB_I     = 19'b0_0_0_0_0_00_0_00_0_000_0_1_0_1_0;
  localparam logic [18:0] WB_LW    = 19'b0_0_0_0_0_00_0_00_0_000_0_1_1_1_0;
  localparam logic [18:0] TRAP_C   = 19'b0_0_0_0_0_00_0_00_0_000_0_0_0_0_1;

  function automatic logic [18:0] ctrl_now();
    return {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
            bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.ext_zero,
            bus.alu_op, bus.reg_dest, bus.reg_write, bus.mem_to_reg,
            bus.retire, bus.trap};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Inputs are set at posedge+1; check the settled outputs, then advance a cycle
  task automatic cycle(input string tag, input logic [18:0] c, input logic [2:0] s);
    #1;
    check({tag, ".ctrl"},  32'(ctrl_now()),  32'(c));
    check({tag, ".state"}, 32'(bus.state),   32'(s));
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [31:0] ir);
    bus.opcode = ir[31:26];
    bus.funct  = ir[5:0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Run FETCH (ack immediate) and DECODE for the given instruction
  task automatic fetch_decode(input string tag, input logic [31:0] ir);
    set_ir(ir);
    bus.mem_ack = 1'b1;
    cycle({tag, ".F"}, F_ACK, 3'd0);
    cycle({tag, ".D"}, DEC, 3'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_ack = 1'b0;
    bus.zero    = 1'b0;
    set_ir(32'h0022_9821);

    // Reset: outputs forced low even with ack high
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b1;
    cycle("rst_hold", ZERO_C, 3'd0);
    rst = 1'b0;

    // addu: 0,1,2,4 then back to 0
    fetch_decode("addu", 32'h0022_9821);
    cycle("addu.E", EX_R_ADD, 3'd2);
    cycle("addu.W", WB_R, 3'd4);

    // lw with 3 wait cycles in MEM
    fetch_decode("lw", 32'h8C22_9821);
    cycle("lw.E", EX_IMM, 3'd2);
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) cycle("lw.Mwait", MEM_LW, 3'd3);
    bus.mem_ack = 1'b1;
    cycle("lw.Mack", MEM_LW, 3'd3);
    cycle("lw.W", WB_LW, 3'd4);

    // sw: one wait, retire on ack, then FETCH
    fetch_decode("sw", 32'hAC22_9821);
    cycle("sw.E", EX_IMM, 3'd2);
    bus.mem_ack = 1'b0;
    cycle("sw.Mwait", MEM_SW, 3'd3);
    bus.mem_ack = 1'b1;
    cycle("sw.Mack", MEM_SWA, 3'd3);

    // Branches and jump
    fetch_decode("beq1", 32'h1022_9821);
    bus.zero = 1'b1;
    cycle("beq1.E", EX_BR_T, 3'd2);
    fetch_decode("beq0", 32'h1022_9821);
    bus.zero = 1'b0;
    cycle("beq0.E", EX_BR_N, 3'd2);
    fetch_decode("bne1", 32'h1422_9821);
    bus.zero = 1'b1;
    cycle("bne1.E", EX_BR_N, 3'd2);
    fetch_decode("bne0", 32'h1422_9821);
    bus.zero = 1'b0;
    cycle("bne0.E", EX_BR_T, 3'd2);
    fetch_decode("j", 32'h0822_9821);
    cycle("j.E", EX_J, 3'd2);

    // andi, sub, slt
    fetch_decode("andi", 32'h3022_9821);
    cycle("andi.E", EX_ANDI, 3'd2);
    cycle("andi.W", WB_I, 3'd4);
    fetch_decode("sub", 32'h0022_9822);
    cycle("sub.E", EX_R_SUB, 3'd2);
    cycle("sub.W", WB_R, 3'd4);
    fetch_decode("slt", 32'h0022_982A);
    cycle("slt.E", EX_R_SLT, 3'd2);
    cycle("slt.W", WB_R, 3'd4);

    // Illegal opcode 0x3F: sticky trap, no requests
    fetch_decode("ill", 32'hFC22_9821);
    for (int i = 0; i < 22; i++) begin
      bus.mem_ack = i[0];
      cycle("ill.trap", TRAP_C, 3'd7);
    end
    rst = 1'b1;
    cycle("ill.rst", ZERO_C, 3'd0);
    rst = 1'b0;
    bus.mem_ack = 1'b0;
    cycle("ill.refetch", F_WAIT, 3'd0);

    // Illegal R-type funct traps after DECODE
    do_reset();
    fetch_decode("badfn", 32'h0000_0000);
    cycle("badfn.trap", TRAP_C, 3'd7);

    // FETCH timeout: 15 unanswered cycles, then TRAP
    do_reset();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 15; i++) cycle("to.wait", F_WAIT, 3'd0);
    cycle("to.trap", TRAP_C, 3'd7);
    bus.mem_ack = 1'b1;
    cycle("to.sticky", TRAP_C, 3'd7);

    // Ack on the 15th cycle wins over the timeout
    do_reset();
    set_ir(32'h0022_9821);
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 14; i++) cycle("ack15.wait", F_WAIT, 3'd0);
    bus.mem_ack = 1'b1;
    cycle("ack15.ack", F_ACK, 3'd0);
    cycle("ack15.D", DEC, 3'd1);

    // Reset pulse during a lw MEM wait
    do_reset();
    fetch_decode("lwrst", 32'h8C22_9821);
    cycle("lwrst.E", EX_IMM, 3'd2);
    bus.mem_ack = 1'b0;
    cycle("lwrst.Mwait", MEM_LW, 3'd3);
    rst = 1'b1;
    cycle("lwrst.rst", ZERO_C, 3'd0);
    rst = 1'b0;
    cycle("lwrst.refetch", F_WAIT, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
